// File: rtl/psx_pkg.sv
// rtl/psx_pkg.sv - PSX pad protocol constants, pad state encoding and reply table.
package psx_pkg;

   localparam logic [7:0] PSX_CMD_START  = 8'h01;
   localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
   localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
   localparam logic [7:0] PSX_READY      = 8'h5A;

   typedef enum logic [2:0] {
      PAD_IDLE      = 3'd0,
      PAD_SHIFT     = 3'd1,
      PAD_ACK_WAIT  = 3'd2,
      PAD_ACK_PULSE = 3'd3,
      PAD_DONE      = 3'd4,
      PAD_IGNORE    = 3'd5
   } pad_state_e;

   // Reply byte sent during byte slot idx of a standard poll.
   function automatic logic [7:0] psx_reply_byte(input logic [2:0] idx,
                                                 input logic [7:0] pad_id,
                                                 input logic [15:0] btn);
      logic [7:0] r;
      case (idx)
         3'd0:    r = 8'hFF;
         3'd1:    r = pad_id;
         3'd2:    r = PSX_READY;
         3'd3:    r = btn[7:0];
         3'd4:    r = btn[15:8];
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// rtl/psx_sync_edge.sv - 2-FF synchronizer with registered rise/fall pulses, idles high.
module psx_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic rise_q;
   logic fall_q;

   // Edges come from the s1/s2 pair so a pin edge is usable after two clocks.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         rise_q <= s1_q & ~s2_q;
         fall_q <= ~s1_q & s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/psx_pad_responder.sv
// rtl/psx_pad_responder.sv - Emulated PSX digital pad answering the 01/42 poll with
// a 5-byte reply, pulsing ack between bytes.
module psx_pad_responder
   import psx_pkg::*;
#(
   parameter int unsigned ACK_DELAY = 16,
   parameter int unsigned ACK_LEN   = 8,
   parameter logic [7:0]  PAD_ID    = PSX_ID_DIGITAL
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        att_i,
   input  logic        psx_clk_i,
   input  logic        cmd_i,
   input  logic [15:0] buttons_n_i,
   output logic        data_o,
   output logic        ack_o,
   output logic        busy_o,
   output logic        poll_done_o,
   output logic        cmd_error_o
);

   localparam logic [15:0] DELAY_LAST = 16'(ACK_DELAY - 1);
   localparam logic [15:0] LEN_LAST   = 16'(ACK_LEN - 1);

   logic att_lvl_unused, att_rise, att_fall;
   logic pclk_lvl_unused, pclk_rise, pclk_fall_unused;
   logic cmd_lvl, cmd_rise_unused, cmd_fall_unused;

   psx_sync_edge u_sync_att (
      .clk_i(clk_i), .rst_i(reset_i), .d_i(att_i),
      .level_o(att_lvl_unused), .rise_o(att_rise), .fall_o(att_fall)
   );

   psx_sync_edge u_sync_pclk (
      .clk_i(clk_i), .rst_i(reset_i), .d_i(psx_clk_i),
      .level_o(pclk_lvl_unused), .rise_o(pclk_rise), .fall_o(pclk_fall_unused)
   );

   psx_sync_edge u_sync_cmd (
      .clk_i(clk_i), .rst_i(reset_i), .d_i(cmd_i),
      .level_o(cmd_lvl), .rise_o(cmd_rise_unused), .fall_o(cmd_fall_unused)
   );

   pad_state_e  state_q, state_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  rx_q, rx_d;
   logic [15:0] btn_q, btn_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] cnt_q, cnt_d;
   logic        data_q, data_d;
   logic        ack_q, ack_d;
   logic        poll_done_q, poll_done_d;
   logic        cmd_error_q, cmd_error_d;

   logic [7:0]  rx_shift;
   logic [7:0]  exp_cmd;
   logic [7:0]  next_reply;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= PAD_IDLE;
         tx_q        <= 8'hFF;
         rx_q        <= 8'h00;
         btn_q       <= 16'hFFFF;
         byte_idx_q  <= 3'd0;
         bit_cnt_q   <= 3'd0;
         cnt_q       <= 16'd0;
         data_q      <= 1'b1;
         ack_q       <= 1'b1;
         poll_done_q <= 1'b0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         btn_q       <= btn_d;
         byte_idx_q  <= byte_idx_d;
         bit_cnt_q   <= bit_cnt_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         ack_q       <= ack_d;
         poll_done_q <= poll_done_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      btn_d       = btn_q;
      byte_idx_d  = byte_idx_q;
      bit_cnt_d   = bit_cnt_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      ack_d       = ack_q;
      poll_done_d = 1'b0;
      cmd_error_d = 1'b0;
      rx_shift    = {cmd_lvl, rx_q[7:1]};
      exp_cmd     = (byte_idx_q == 3'd0) ? PSX_CMD_START : PSX_CMD_POLL;
      next_reply  = psx_reply_byte(byte_idx_q + 3'd1, PAD_ID, btn_q);

      // Attention release aborts everything, even a bit arriving on the same cycle.
      if (att_rise) begin
         state_d    = PAD_IDLE;
         data_d     = 1'b1;
         ack_d      = 1'b1;
         byte_idx_d = 3'd0;
         bit_cnt_d  = 3'd0;
         cnt_d      = 16'd0;
      end else begin
         case (state_q)
            PAD_IDLE: begin
               if (att_fall) begin
                  state_d    = PAD_SHIFT;
                  btn_d      = buttons_n_i;
                  byte_idx_d = 3'd0;
                  bit_cnt_d  = 3'd0;
                  tx_d       = 8'hFF;
                  data_d     = 1'b1;
               end
            end
            PAD_SHIFT: begin
               if (pclk_rise) begin
                  rx_d      = rx_shift;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     data_d = 1'b1;
                     cnt_d  = 16'd0;
                     if ((byte_idx_q <= 3'd1) && (rx_shift != exp_cmd)) begin
                        state_d     = PAD_IGNORE;
                        cmd_error_d = 1'b1;
                     end else if (byte_idx_q == 3'd4) begin
                        state_d     = PAD_DONE;
                        poll_done_d = 1'b1;
                     end else begin
                        state_d = PAD_ACK_WAIT;
                     end
                  end else begin
                     tx_d   = {1'b1, tx_q[7:1]};
                     data_d = tx_q[1];
                  end
               end
            end
            PAD_ACK_WAIT: begin
               if (cnt_q == DELAY_LAST) begin
                  state_d = PAD_ACK_PULSE;
                  ack_d   = 1'b0;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            PAD_ACK_PULSE: begin
               if (cnt_q == LEN_LAST) begin
                  state_d    = PAD_SHIFT;
                  ack_d      = 1'b1;
                  cnt_d      = 16'd0;
                  bit_cnt_d  = 3'd0;
                  byte_idx_d = byte_idx_q + 3'd1;
                  tx_d       = next_reply;
                  data_d     = next_reply[0];
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
            PAD_DONE, PAD_IGNORE: begin
               data_d = 1'b1;
               ack_d  = 1'b1;
            end
            default: state_d = PAD_IDLE;
         endcase
      end
   end

   assign data_o      = data_q;
   assign ack_o       = ack_q;
   assign busy_o      = (state_q != PAD_IDLE);
   assign poll_done_o = poll_done_q;
   assign cmd_error_o = cmd_error_q;

endmodule

// File: tb/tb_psx_pad_responder.sv
// tb/tb_psx_pad_responder.sv - Self-checking bench: randomized host polls vs. a
// byte-level protocol model.
module tb_psx_pad_responder;

   localparam int ACK_DELAY = 16;
   localparam int ACK_LEN   = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        att = 1'b1;
   logic        psx_clk = 1'b1;
   logic        cmd = 1'b1;
   logic [15:0] buttons_n = 16'hFFFF;
   logic        data, ack, busy, poll_done, cmd_error;

   int   cyc = 0, rise_cyc = 0, fall_cyc = 0, dly_last = 0, wid_last = 0;
   int   ack_cnt = 0, done_cnt = 0, err_cnt = 0;
   logic ack_prev = 1'b1;
   int   n_cmp = 0, n_fail = 0;

   psx_pad_responder #(.ACK_DELAY(ACK_DELAY), .ACK_LEN(ACK_LEN), .PAD_ID(8'h41)) dut (
      .clk_i(clk), .reset_i(reset), .att_i(att), .psx_clk_i(psx_clk), .cmd_i(cmd),
      .buttons_n_i(buttons_n), .data_o(data), .ack_o(ack), .busy_o(busy),
      .poll_done_o(poll_done), .cmd_error_o(cmd_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ack_prev && !ack) begin
         fall_cyc = cyc;
         dly_last = cyc - rise_cyc;
      end
      if (!ack_prev && ack) begin
         wid_last = cyc - fall_cyc;
         ack_cnt++;
      end
      ack_prev = ack;
      if (poll_done) done_cnt++;
      if (cmd_error) err_cnt++;
   end

   // Protocol model: reply table, command checks, ack after every byte but the last.
   function automatic void model_poll(input logic [39:0] cmds, input logic [15:0] btn,
                                      output logic [39:0] erx, output logic [11:0] ecnts);
      logic [7:0] rep;
      int acks, done, err;
      erx = '1; acks = 0; done = 0; err = 0;
      for (int by = 0; by < 5; by++) begin
         if (err == 0 && done == 0) begin
            case (by)
               0: rep = 8'hFF;
               1: rep = 8'h41;
               2: rep = 8'h5A;
               3: rep = btn[7:0];
               default: rep = btn[15:8];
            endcase
            erx[by*8 +: 8] = rep;
            if ((by == 0 && cmds[7:0] != 8'h01) || (by == 1 && cmds[15:8] != 8'h42)) err = 1;
            else if (by == 4) done = 1;
            else acks++;
         end
      end
      ecnts = {4'(acks), 4'(done), 4'(err)};
   endfunction

   task automatic host_bit(input int hp, input logic c, output logic d);
      psx_clk = 1'b0;
      cmd = c;
      repeat (hp) @(negedge clk);
      d = data;
      psx_clk = 1'b1;
      rise_cyc = cyc;
      repeat (hp) @(negedge clk);
   endtask

   task automatic run_poll(input int hp, input logic [39:0] cmds, input logic [15:0] btn,
                           input int chg_byte, input logic [15:0] chg_val,
                           input int abort_byte, input int gap,
                           output logic [39:0] rx, output logic [11:0] cnts,
                           output logic [31:0] tim, output logic [2:0] post);
      int a0, d0, e0, ab, t, dmin, dmax, wmin, wmax;
      logic b, aborted;
      a0 = ack_cnt; d0 = done_cnt; e0 = err_cnt;
      dmin = 255; dmax = 0; wmin = 255; wmax = 0;
      rx = '1; aborted = 1'b0;
      buttons_n = btn;
      att = 1'b0;
      repeat (hp) @(negedge clk);
      for (int by = 0; by < 5; by++) begin
         if (by == chg_byte) buttons_n = chg_val;
         for (int i = 0; i < 8; i++) begin
            if (by == abort_byte && i == 3) aborted = 1'b1;
            if (!aborted) begin
               host_bit(hp, cmds[by*8+i], b);
               rx[by*8+i] = b;
            end
         end
         if (!aborted) begin
            ab = ack_cnt;
            t = 0;
            while (ack_cnt == ab && t < 40) begin
               @(negedge clk);
               t++;
            end
            if (ack_cnt != ab) begin
               if (dly_last < dmin) dmin = dly_last;
               if (dly_last > dmax) dmax = dly_last;
               if (wid_last < wmin) wmin = wid_last;
               if (wid_last > wmax) wmax = wid_last;
            end
         end
      end
      att = 1'b1;
      repeat (3) @(negedge clk);
      post = {busy, data, ack};
      repeat (gap - 3) @(negedge clk);
      cnts = {4'(ack_cnt - a0), 4'(done_cnt - d0), 4'(err_cnt - e0)};
      tim = {8'(dmin), 8'(dmax), 8'(wmin), 8'(wmax)};
   endtask

   localparam logic [31:0] TIM_OK = {8'(ACK_DELAY + 3), 8'(ACK_DELAY + 3), 8'(ACK_LEN), 8'(ACK_LEN)};

   task automatic test_reset();
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (data !== 1'b1) begin n_fail++; $display("FAIL reset_data: got %b want 1", data); end
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %b want 1", ack); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (poll_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", poll_done); end
      n_cmp++; if (cmd_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cmd_error); end
   endtask

   task automatic test_full_poll();
      logic [39:0] cmds, rx, erx;
      logic [15:0] btn;
      logic [11:0] cnts, ecnts;
      logic [31:0] tim;
      logic [2:0]  post;
      int hp;
      for (int k = 0; k < 5; k++) begin
         if (k == 0) begin
            hp = 20; btn = 16'hFFFE; cmds = 40'h00_00_00_42_01;
         end else begin
            hp = $urandom_range(4, 24); btn = 16'($urandom);
            cmds = {8'($urandom), 8'($urandom), 8'($urandom), 8'h42, 8'h01};
         end
         model_poll(cmds, btn, erx, ecnts);
         run_poll(hp, cmds, btn, -1, 16'h0, -1, 2 * hp, rx, cnts, tim, post);
         n_cmp++; if (rx !== erx) begin n_fail++; $display("FAIL full_rx[%0d]: got %h want %h", k, rx, erx); end
         n_cmp++; if (cnts !== ecnts) begin n_fail++; $display("FAIL full_cnts[%0d]: got %h want %h", k, cnts, ecnts); end
         n_cmp++; if (tim !== TIM_OK) begin n_fail++; $display("FAIL full_ack_timing[%0d]: got %h want %h", k, tim, TIM_OK); end
         n_cmp++; if (post !== 3'b011) begin n_fail++; $display("FAIL full_post[%0d]: got %b want 011", k, post); end
      end
   endtask

   task automatic test_bad_cmd();
      logic [39:0] cmds, rx, erx;
      logic [15:0] btn;
      logic [11:0] cnts, ecnts;
      logic [31:0] tim;
      logic [2:0]  post;
      logic [7:0]  bad;
      for (int k = 0; k < 4; k++) begin
         btn = 16'($urandom);
         do bad = 8'($urandom); while (bad == 8'h01 || bad == 8'h42);
         if (k == 0) cmds = {24'h0, 8'h42, 8'h03};
         else if (k % 2 == 1) cmds = {24'($urandom), 8'h42, bad};
         else cmds = {24'($urandom), bad, 8'h01};
         model_poll(cmds, btn, erx, ecnts);
         run_poll(10, cmds, btn, -1, 16'h0, -1, 20, rx, cnts, tim, post);
         n_cmp++; if (rx !== erx) begin n_fail++; $display("FAIL bad_rx[%0d]: got %h want %h", k, rx, erx); end
         n_cmp++; if (cnts !== ecnts) begin n_fail++; $display("FAIL bad_cnts[%0d]: got %h want %h", k, cnts, ecnts); end
         n_cmp++; if (post !== 3'b011) begin n_fail++; $display("FAIL bad_post[%0d]: got %b want 011", k, post); end
      end
   endtask

   task automatic test_button_latch();
      logic [39:0] rx, erx;
      logic [11:0] cnts, ecnts;
      logic [31:0] tim;
      logic [2:0]  post;
      model_poll(40'h0000004201, 16'h5AA5, erx, ecnts);
      run_poll(12, 40'h0000004201, 16'h5AA5, 2, 16'h0000, -1, 24, rx, cnts, tim, post);
      n_cmp++; if (rx[39:24] !== 16'h5AA5) begin n_fail++; $display("FAIL latch_btn_bytes: got %h want 5aa5", rx[39:24]); end
      n_cmp++; if (rx !== erx) begin n_fail++; $display("FAIL latch_rx: got %h want %h", rx, erx); end
      n_cmp++; if (cnts !== ecnts) begin n_fail++; $display("FAIL latch_cnts: got %h want %h", cnts, ecnts); end
   endtask

   task automatic test_att_abort();
      logic [39:0] rx, erx;
      logic [15:0] btn;
      logic [11:0] cnts, ecnts;
      logic [31:0] tim;
      logic [2:0]  post;
      btn = 16'($urandom);
      run_poll(8, 40'h0000004201, btn, -1, 16'h0, 3, 4, rx, cnts, tim, post);
      n_cmp++; if (post !== 3'b011) begin n_fail++; $display("FAIL abort_post: got %b want 011", post); end
      n_cmp++; if (cnts !== 12'h300) begin n_fail++; $display("FAIL abort_cnts: got %h want 300", cnts); end
      btn = 16'($urandom);
      model_poll(40'h0000004201, btn, erx, ecnts);
      run_poll(8, 40'h0000004201, btn, -1, 16'h0, -1, 16, rx, cnts, tim, post);
      n_cmp++; if (rx !== erx) begin n_fail++; $display("FAIL abort_repoll_rx: got %h want %h", rx, erx); end
      n_cmp++; if (cnts !== ecnts) begin n_fail++; $display("FAIL abort_repoll_cnts: got %h want %h", cnts, ecnts); end
   endtask

   task automatic test_reset_in_ack();
      logic [39:0] rx, erx;
      logic [15:0] btn;
      logic [11:0] cnts, ecnts;
      logic [31:0] tim;
      logic [2:0]  post;
      logic [7:0]  c0;
      logic b;
      int t;
      c0 = 8'h01;
      att = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) host_bit(10, c0[i], b);
      t = 0;
      while (ack !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack_seen_low: got %b want 0", ack); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_ack_immediate: got %b want 1", ack); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      att = 1'b1;
      psx_clk = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      btn = 16'($urandom);
      model_poll(40'h0000004201, btn, erx, ecnts);
      run_poll(10, 40'h0000004201, btn, -1, 16'h0, -1, 20, rx, cnts, tim, post);
      n_cmp++; if (rx !== erx) begin n_fail++; $display("FAIL rst_repoll_rx: got %h want %h", rx, erx); end
      n_cmp++; if (cnts !== ecnts) begin n_fail++; $display("FAIL rst_repoll_cnts: got %h want %h", cnts, ecnts); end
   endtask

   task automatic test_back_to_back();
      logic [39:0] cmds, rx, erx;
      logic [15:0] btn;
      logic [11:0] cnts, ecnts;
      logic [31:0] tim;
      logic [2:0]  post;
      int hp;
      hp = $urandom_range(4, 16);
      for (int k = 0; k < 2; k++) begin
         btn = 16'($urandom);
         cmds = {24'($urandom), 8'h42, 8'h01};
         model_poll(cmds, btn, erx, ecnts);
         run_poll(hp, cmds, btn, -1, 16'h0, -1, 2 * hp, rx, cnts, tim, post);
         n_cmp++; if (rx !== erx) begin n_fail++; $display("FAIL b2b_rx[%0d]: got %h want %h", k, rx, erx); end
         n_cmp++; if (cnts !== ecnts) begin n_fail++; $display("FAIL b2b_cnts[%0d]: got %h want %h", k, cnts, ecnts); end
         n_cmp++; if (tim !== TIM_OK) begin n_fail++; $display("FAIL b2b_ack_timing[%0d]: got %h want %h", k, tim, TIM_OK); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_full_poll();
      test_bad_cmd();
      test_button_latch();
      test_att_abort();
      test_reset_in_ack();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/psx_pad_responder.md
# psx_pad_responder

Emulated PSX digital controller: the device-side stage that consumes the host's `att`/`psx_clk`/`cmd` lines and produces `data` and `ack`. It oversamples the slow host link on the fast system clock, answers the standard poll (0x01, 0x42) with a 5-byte reply ending in the latched button state, and pulses `ack` between bytes so the host can re-arm its byte counter. It is used to close the loop on the host poller in simulation and on the board.

## Interface
- `ACK_DELAY`, default 16: clk cycles from the 8th `psx_clk` rise of a byte to `ack` falling.
- `ACK_LEN`, default 8: clk cycles `ack` is held low.
- `PAD_ID`, default 8'h41: ID byte returned in byte 1 (digital pad).
- `clk`  in  1: system clock, much faster than `psx_clk`; the only clock.
- `reset`  in  1: asynchronous, active-high.
- `att`  in  1: host attention, active low, asynchronous to `clk`.
- `psx_clk`  in  1: host serial clock, idle high, asynchronous.
- `cmd`  in  1: host command bit, LSB first, asynchronous.
- `buttons_n`  in  16: live button state, active low (bit 0 = SELECT … bit 15 = SQUARE).
- `data`  out  1: reply bit, LSB first, idle high.
- `ack`  out  1: inter-byte acknowledge, active-low pulse, idle high.
- `busy`  out  1: high while a transaction is in progress.
- `poll_done`  out  1: one-cycle pulse after the final byte completes.
- `cmd_error`  out  1: one-cycle pulse when a command byte mismatches.

## Operation
- `att`, `psx_clk` and `cmd` each pass through a 2-FF synchronizer. Edges are then detected on the synchronized signals.
- States: IDLE, SHIFT, ACK_WAIT, ACK_PULSE, DONE, IGNORE.
- IDLE → SHIFT on synchronized `att` falling:
  - latch `buttons_n` into `btn_q`;
  - set byte_idx=0, bit_cnt=0;
  - load tx = 8'hFF;
  - drive `data` = tx[0].
- Reply bytes by byte_idx: 0:8'hFF, 1:`PAD_ID`, 2:8'h5A, 3:`btn_q[7:0]`, 4:`btn_q[15:8]`.
- Expected commands: byte 0 = 8'h01, byte 1 = 8'h42. Bytes 2–4 are don't-care.
- SHIFT, on each synchronized `psx_clk` rise:
  - sample `cmd` into rx (rx <= {cmd, rx[7:1]});
  - shift tx right, fill bit 1;
  - drive `data` = next tx bit;
  - increment bit_cnt (3-bit, wraps 7→0).
- On the 8th rise, `data` returns high and the state branches:
  - byte_idx 0 or 1 with rx mismatch → IGNORE, pulse `cmd_error`;
  - byte_idx < 4 otherwise → ACK_WAIT;
  - byte_idx == 4 → DONE, pulse `poll_done`.
- ACK_WAIT: count `ACK_DELAY` cycles → ACK_PULSE.
- ACK_PULSE: `ack`=0 for `ACK_LEN` cycles. On exit, `ack`=1, byte_idx++, load the next reply byte, drive bit 0, → SHIFT.
- `psx_clk` edges in ACK_WAIT, ACK_PULSE, DONE and IGNORE are ignored.
- DONE and IGNORE hold `data`=1, `ack`=1 and wait for `att` high.
- Synchronized `att` rising in any state → IDLE:
  - `data`=1, `ack`=1;
  - counters cleared;
  - no `poll_done` or `cmd_error` generated.
- `busy` = (state != IDLE).

## Timing
- Reset values: `data`=1, `ack`=1, `busy`=0, `poll_done`=0, `cmd_error`=0, state=IDLE. All are applied immediately on `reset`, including mid-transaction.
- Pin-to-output latency:
  - `psx_clk` rise → `data` update: 3 clk cycles (2 sync + 1 register);
  - `att` fall → bit 0 on `data`: 3 clk cycles.
- Host constraints:
  - `psx_clk` high and low phases ≥ 4 clk cycles each;
  - `data` is stable from 3 cycles after a rise until the next rise + 3, so it is valid at the host's falling-edge sample.
- `ack` falls exactly `ACK_DELAY`+3 clk cycles after the pin-level 8th rise and stays low exactly `ACK_LEN` cycles.
- `buttons_n` is sampled once per transaction, in the cycle IDLE→SHIFT. Later changes do not affect the reply.
- `att` rising on the same cycle as a `psx_clk` rise: `att` wins; the bit is discarded.
- `att` falling while in IDLE after reset: handled normally; no minimum idle time.

## Structure
- Shared package `psx_pkg`:
  - constants PSX_CMD_START=8'h01, PSX_CMD_POLL=8'h42, PSX_ID_DIGITAL=8'h41, PSX_READY=8'h5A;
  - the pad state enum, so the host-side bench can decode it.
- Sub-module `psx_sync_edge`: 2-FF synchronizer with registered rise/fall pulses, reset to 1. Instantiated for `att`, `psx_clk` and `cmd`; rise/fall pulses unused on `cmd`.

## Test plan
- Full poll, host half-period 20 clk, `buttons_n`=16'hFFFE:
  - host sends 01,42,00,00,00;
  - `data` bytes read FF,41,5A,FE,FF;
  - 4 `ack` pulses, each 8 cycles low;
  - one `poll_done`; no `cmd_error`.
- Bad start byte: host sends 8'h03 first.
  - one `cmd_error` after byte 0;
  - no `ack`;
  - `data` stays 1 until `att` rises, then `busy`=0.
- Button latch: `buttons_n`=16'h5AA5 at `att` fall, changed to 16'h0000 during byte 2.
  - bytes 3–4 read A5,5A.
- `att` abort: raise `att` after 3 bits of byte 3.
  - within 3 cycles: IDLE, `data`=1, `ack`=1;
  - no `poll_done`;
  - an immediate new poll returns the correct FF,41,5A,….
- Async reset during ACK_PULSE:
  - `ack` returns to 1 in the same cycle;
  - `busy`=0;
  - after release, a fresh poll completes normally.
- Back-to-back polls separated by 1 host clock period of `att` high: both complete with correct data and 4 acks each.
